sobel_window_fetch: RTL and testbench
=====================================

SOBEL_WINDOW_FETCH -- requirements
Module: sobel_window_fetch

Interface
REQ-001 Parameter BORDER_VALUE, default 8'd0: pixel value substituted for any neighbor that lies outside the 128x128 image.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 fetch_start  input  1  request to fetch one 3x3 window; level-sampled, accepted only in IDLE.
REQ-005 px_xcoord  input  7  center column; sampled on the accepting edge.
REQ-006 px_ycoord  input  7  center row; sampled on the accepting edge.
REQ-007 bram_read_addr  output  14  read address to the 128x128 input image BRAM, formatted {row[6:0], col[6:0]}.
REQ-008 bram_read_data  input  8  BRAM read data, valid one cycle after its address (registered read).
REQ-009 window_p0 .. window_p8  output  8 each  registered window, row-major: p0=(x-1,y-1), p1=(x,y-1), p2=(x+1,y-1), p3=(x-1,y), p4=(x,y), p5=(x+1,y), p6=(x-1,y+1), p7=(x,y+1), p8=(x+1,y+1).
REQ-010 fetch_done  output  1  one-cycle pulse: window complete and stable.
REQ-011 busy  output  1  high while a fetch is in progress.

Function
REQ-012 The FSM SHALL have three states: IDLE, ISSUE (neighbor index k = 0..8), and DRAIN (capture of the last read).
REQ-013 IDLE SHALL move to ISSUE with k=0 and latch the coordinates at edge E0 when fetch_start=1; otherwise it stays in IDLE.
REQ-014 In ISSUE with index k, bram_read_addr SHALL carry neighbor k's address for that whole cycle; k increments at each edge, and ISSUE moves to DRAIN after k=8.
REQ-015 Neighbor k SHALL be captured into window_pk at the edge one cycle after its address cycle, so neighbor k is captured at edge E(k+2).
REQ-016 DRAIN SHALL capture p8 at E10, return to IDLE, and assert fetch_done for exactly the cycle E10..E11.
REQ-017 The start-to-done latency SHALL be 10 cycles, fixed and independent of coordinates.
REQ-018 Neighbor coordinates SHALL be computed without wrap-around.
REQ-019 A neighbor SHALL be out of bounds when (x=0, dx=-1), (x=127, dx=+1), (y=0, dy=-1) or (y=127, dy=+1).
REQ-020 For an out-of-bounds neighbor, bram_read_addr SHALL be 14'd0 in its issue cycle, and the capture SHALL store BORDER_VALUE instead of bram_read_data.
REQ-021 bram_read_addr SHALL be 14'd0 in every cycle that is not an ISSUE cycle.
REQ-022 window_p0..p8 SHALL change only on capture edges and hold their values until the next fetch overwrites them.
REQ-023 busy SHALL be 1 from E0 up to E10 and 0 from E10 onward, so busy and fetch_done are never high together.
REQ-024 fetch_start SHALL be ignored while busy=1, with no effect on the state, the latched coordinates or the window.
REQ-025 fetch_start=1 in the fetch_done cycle SHALL be accepted at E11 (back-to-back fetches, 11-cycle period).
REQ-026 Coordinate changes during busy SHALL have no effect on the fetch in progress.

Reset
REQ-027 While rst=1, and immediately on its assertion, the block SHALL force: state=IDLE, k=0, latched coordinates=0, window_p0..p8=8'd0, bram_read_addr=14'd0, fetch_done=0, busy=0.
REQ-028 Reset asserted mid-fetch SHALL abort the fetch without any fetch_done pulse, and the first fetch after reset release SHALL behave exactly as from power-up.

Verification (BRAM model: pixel(x,y) = (x + 2y + 1) mod 256, 1-cycle read latency, BORDER_VALUE=0)
REQ-029 Interior: start at (10,20) -> addresses in cycles 1..9 are {19,9},{19,10},{19,11},{20,9},...,{21,11}; done 10 cycles after acceptance; p0=48, p4=51, p8=54.
REQ-030 Corner (0,0): -> p4=1, p5=2, p7=3, p8=4; p0,p1,p2,p3,p6=0; OOB cycles drive address 0; latency still 10.
REQ-031 Corner (127,127): -> p0=123, p1=124, p3=125, p4=126; p2,p5,p6,p7,p8=0; no issued address has wrapped to row/col 0 except the OOB zero-address cycles.
REQ-032 Busy: fetch_start held high continuously, coordinates toggled mid-fetch -> exactly one fetch per 11 cycles, busy=0 during each done pulse, every window matches the coordinates latched at its acceptance edge.
REQ-033 Reset mid-op: rst pulsed in cycle 5 of a fetch at (10,20) -> all outputs 0 at once, no done pulse; next fetch at (64,64) returns p4=193 with done at 10 cycles.

Source files
------------

// File: rtl/sobel_window_fetch.sv
// Fetches the 3x3 neighbourhood around a pixel from a registered-read image BRAM.
// Out-of-image neighbours are substituted with BORDER_VALUE and never issue a real read.
module sobel_window_fetch #(
  parameter logic [7:0] BORDER_VALUE = 8'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [6:0]  px_xcoord,
  input  logic [6:0]  px_ycoord,
  output logic [13:0] bram_read_addr,
  input  logic [7:0]  bram_read_data,
  output logic [7:0]  window_p0,
  output logic [7:0]  window_p1,
  output logic [7:0]  window_p2,
  output logic [7:0]  window_p3,
  output logic [7:0]  window_p4,
  output logic [7:0]  window_p5,
  output logic [7:0]  window_p6,
  output logic [7:0]  window_p7,
  output logic [7:0]  window_p8,
  output logic        fetch_done,
  output logic        busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] k_q, k_d;
  logic [6:0] x_q, x_d, y_q, y_d;
  logic       cap_valid_q, cap_valid_d;
  logic [3:0] cap_idx_q, cap_idx_d;
  logic       cap_oob_q, cap_oob_d;
  logic       done_q, done_d;
  logic [7:0] win_q [9];

  logic [1:0] col_sel, row_sel;
  logic [6:0] nx, ny;
  logic       oob;

  // col_sel/row_sel: 0 = minus one, 1 = centre, 2 = plus one
  always_comb begin
    col_sel = 2'd1;
    row_sel = 2'd1;
    case (k_q)
      4'd0, 4'd3, 4'd6: col_sel = 2'd0;
      4'd2, 4'd5, 4'd8: col_sel = 2'd2;
      default:          col_sel = 2'd1;
    endcase
    if (k_q < 4'd3)      row_sel = 2'd0;
    else if (k_q < 4'd6) row_sel = 2'd1;
    else                 row_sel = 2'd2;

    nx = x_q;
    ny = y_q;
    if (col_sel == 2'd0)      nx = x_q - 7'd1;
    else if (col_sel == 2'd2) nx = x_q + 7'd1;
    if (row_sel == 2'd0)      ny = y_q - 7'd1;
    else if (row_sel == 2'd2) ny = y_q + 7'd1;

    oob = ((col_sel == 2'd0) && (x_q == 7'd0))   ||
          ((col_sel == 2'd2) && (x_q == 7'd127)) ||
          ((row_sel == 2'd0) && (y_q == 7'd0))   ||
          ((row_sel == 2'd2) && (y_q == 7'd127));
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    x_d         = x_q;
    y_d         = y_q;
    done_d      = 1'b0;
    cap_valid_d = (state_q == S_ISSUE);
    cap_idx_d   = k_q;
    cap_oob_d   = oob;
    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          state_d = S_ISSUE;
          k_d     = 4'd0;
          x_d     = px_xcoord;
          y_d     = px_ycoord;
        end
      end
      S_ISSUE: begin
        if (k_q == 4'd8) begin
          state_d = S_DRAIN;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_DRAIN: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      x_q         <= '0;
      y_q         <= '0;
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      cap_oob_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      cap_oob_q   <= cap_oob_d;
      done_q      <= done_d;
    end
  end

  // Capture lags the issue cycle by one edge to match the BRAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 9; i++) begin
        if (cap_valid_q && (cap_idx_q == 4'(i)))
          win_q[i] <= cap_oob_q ? BORDER_VALUE : bram_read_data;
      end
    end
  end

  assign bram_read_addr = ((state_q == S_ISSUE) && !oob) ? {ny, nx} : '0;
  assign fetch_done     = done_q;
  assign busy           = (state_q != S_IDLE);

  assign window_p0 = win_q[0];
  assign window_p1 = win_q[1];
  assign window_p2 = win_q[2];
  assign window_p3 = win_q[3];
  assign window_p4 = win_q[4];
  assign window_p5 = win_q[5];
  assign window_p6 = win_q[6];
  assign window_p7 = win_q[7];
  assign window_p8 = win_q[8];

endmodule

// File: tb/tb_sobel_window_fetch.sv
// Directed bench for sobel_window_fetch against a BRAM holding pixel(x,y) = (x + 2y + 1) mod 256.
module tb_sobel_window_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic [6:0]  px_xcoord, px_ycoord;
  logic [13:0] bram_read_addr;
  logic [7:0]  bram_read_data;
  logic [7:0]  w0, w1, w2, w3, w4, w5, w6, w7, w8;
  logic        fetch_done, busy;
  logic [7:0]  win [9];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sobel_window_fetch #(.BORDER_VALUE(8'd0)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start),
    .px_xcoord(px_xcoord), .px_ycoord(px_ycoord),
    .bram_read_addr(bram_read_addr), .bram_read_data(bram_read_data),
    .window_p0(w0), .window_p1(w1), .window_p2(w2), .window_p3(w3), .window_p4(w4),
    .window_p5(w5), .window_p6(w6), .window_p7(w7), .window_p8(w8),
    .fetch_done(fetch_done), .busy(busy)
  );

  assign win[0] = w0; assign win[1] = w1; assign win[2] = w2;
  assign win[3] = w3; assign win[4] = w4; assign win[5] = w5;
  assign win[6] = w6; assign win[7] = w7; assign win[8] = w8;

  // Image BRAM with one-cycle registered read
  always @(posedge clk)
    bram_read_data <= {1'b0, bram_read_addr[6:0]} + {bram_read_addr[13:7], 1'b0} + 8'd1;

  typedef struct packed {
    logic [6:0]      x;
    logic [6:0]      y;
    logic [8:0][7:0] p;
  } vec_t;

  vec_t tbl [5];

  task automatic setv(input int i, input int x, input int y,
                      input int a0, input int a1, input int a2, input int a3, input int a4,
                      input int a5, input int a6, input int a7, input int a8);
    tbl[i].x = x[6:0];  tbl[i].y = y[6:0];
    tbl[i].p[0] = a0[7:0]; tbl[i].p[1] = a1[7:0]; tbl[i].p[2] = a2[7:0];
    tbl[i].p[3] = a3[7:0]; tbl[i].p[4] = a4[7:0]; tbl[i].p[5] = a5[7:0];
    tbl[i].p[6] = a6[7:0]; tbl[i].p[7] = a7[7:0]; tbl[i].p[8] = a8[7:0];
  endtask

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_addr(input int x, input int y, input int k);
    int nx, ny;
    logic [6:0] cx, cy;
    nx = x + (k % 3) - 1;
    ny = y + (k / 3) - 1;
    if (nx < 0 || nx > 127 || ny < 0 || ny > 127) return 0;
    cx = nx[6:0];
    cy = ny[6:0];
    return int'({cy, cx});
  endfunction

  task automatic chk_win(input string tag, input int i);
    for (int j = 0; j < 9; j++)
      chk($sformatf("%s_p%0d", tag, j), int'(win[j]), int'(tbl[i].p[j]));
  endtask

  // Starts a fetch one cycle before an edge; checks every issue address, busy, and the done timing.
  task automatic run_vec(input int i);
    int x, y;
    x = int'(tbl[i].x);
    y = int'(tbl[i].y);
    fetch_start = 1'b1;
    px_xcoord   = tbl[i].x;
    px_ycoord   = tbl[i].y;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    px_xcoord   = ~tbl[i].x;
    px_ycoord   = ~tbl[i].y;
    for (int t = 0; t < 10; t++) begin
      chk($sformatf("v%0d_addr_c%0d", i, t + 1), int'(bram_read_addr), (t <= 8) ? exp_addr(x, y, t) : 0);
      chk($sformatf("v%0d_busy_c%0d", i, t + 1), int'(busy), 1);
      chk($sformatf("v%0d_done_c%0d", i, t + 1), int'(fetch_done), 0);
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d_done", i), int'(fetch_done), 1);
    chk($sformatf("v%0d_busy_at_done", i), int'(busy), 0);
    chk($sformatf("v%0d_addr_at_done", i), int'(bram_read_addr), 0);
    chk_win($sformatf("v%0d", i), i);
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_drop", i), int'(fetch_done), 0);
    chk_win($sformatf("v%0d_hold", i), i);
  endtask

  initial begin
    logic seen;
    setv(0, 10, 20,   48, 49, 50, 50, 51, 52, 52, 53, 54);
    setv(1, 0, 0,      0, 0, 0, 0, 1, 2, 0, 3, 4);
    setv(2, 127, 127, 123, 124, 0, 125, 126, 0, 0, 0, 0);
    setv(3, 64, 64,   190, 191, 192, 192, 193, 194, 194, 195, 196);
    setv(4, 127, 0,    0, 0, 0, 127, 128, 0, 129, 130, 0);

    rst = 1'b1;
    fetch_start = 1'b0;
    px_xcoord = '0;
    px_ycoord = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", int'(bram_read_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(fetch_done), 0);
    for (int j = 0; j < 9; j++) chk($sformatf("rst_p%0d", j), int'(win[j]), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_vec(i);

    // fetch_start held high; coordinates scrambled mid-fetch, (64,64) presented in the done cycle
    fetch_start = 1'b1;
    px_xcoord = 7'd10;
    px_ycoord = 7'd20;
    @(posedge clk); #1;
    for (int t = 1; t <= 21; t++) begin
      if (t != 11) begin
        px_xcoord = 7'(t * 13);
        px_ycoord = 7'(t * 5);
      end
      @(posedge clk); #1;
      chk($sformatf("bb_done_t%0d", t), int'(fetch_done), (t == 10 || t == 21) ? 1 : 0);
      chk($sformatf("bb_busy_t%0d", t), int'(busy), (t == 10 || t == 21) ? 0 : 1);
      if (t == 10) begin
        chk_win("bb_first", 0);
        px_xcoord = 7'd64;
        px_ycoord = 7'd64;
      end
      if (t == 21) begin
        chk_win("bb_second", 3);
        fetch_start = 1'b0;
      end
    end
    @(posedge clk); #1;
    chk("bb_idle_after", int'(busy), 0);

    // Reset in cycle 5 of a fetch at (10,20)
    fetch_start = 1'b1;
    px_xcoord = 7'd10;
    px_ycoord = 7'd20;
    @(posedge clk); #1;
    fetch_start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", int'(bram_read_addr), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(fetch_done), 0);
    for (int j = 0; j < 9; j++) chk($sformatf("mid_rst_p%0d", j), int'(win[j]), 0);
    seen = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      seen = seen | fetch_done | busy;
    end
    rst = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen = seen | fetch_done | busy;
    end
    chk("mid_rst_no_done", int'(seen), 0);
    run_vec(3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end

endmodule
